result_display_seq: RTL and testbench

//  Parametrised successor to the matrix-result display stage. Captures a snapshot of
//  N_GROUPS result groups (ELEMS words of DATA_W bits each) on a capture pulse, then

---
 rtl/result_display_pkg.sv | 17 +
 rtl/result_display_seq_bank.sv | 42 ++++
 rtl/result_display_seq.sv | 120 ++++++++++++
 tb/tb_result_display_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/result_display_pkg.sv
// rtl/result_display_pkg.sv - shared state encoding for the result display sequencer
package result_display_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Tag widths never collapse to zero so single-group/single-element builds still elaborate.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_display_seq_bank.sv
// rtl/result_display_seq_bank.sv - snapshot register array with load enable and {grp,idx} read mux
module result_bank
  import result_display_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int N_GROUPS = 3,
  parameter int ELEMS    = 4,
  parameter int GRP_W    = clog2_min1(N_GROUPS),
  parameter int IDX_W    = clog2_min1(ELEMS)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             load_i,
  input  logic [N_GROUPS*ELEMS*DATA_W-1:0] results_i,
  input  logic [GRP_W-1:0]                 grp_i,
  input  logic [IDX_W-1:0]                 idx_i,
  output logic [DATA_W-1:0]                word_o
);

  localparam int DEPTH = N_GROUPS * ELEMS;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else if (load_i) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= results_i[k*DATA_W +: DATA_W];
    end
  end

  // Compare-and-select avoids a multiplier on the read path for non-power-of-two ELEMS.
  always_comb begin
    word_o = '0;
    for (int g = 0; g < N_GROUPS; g++) begin
      for (int e = 0; e < ELEMS; e++) begin
        if (grp_i == GRP_W'(g) && idx_i == IDX_W'(e)) word_o = mem_q[g*ELEMS + e];
      end
    end
  end

endmodule

// File: rtl/result_display_seq.sv
// rtl/result_display_seq.sv - captures result groups and streams them as tagged words under valid/ready
module result_display_seq
  import result_display_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int N_GROUPS = 3,
  parameter int ELEMS    = 4,
  localparam int GRP_W   = clog2_min1(N_GROUPS),
  localparam int IDX_W   = clog2_min1(ELEMS)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [N_GROUPS*ELEMS*DATA_W-1:0] results_i,
  input  logic                             capture_i,
  input  logic                             loop_i,
  input  logic                             abort_i,
  output logic [DATA_W-1:0]                dout_o,
  output logic                             dout_valid_o,
  input  logic                             dout_ready_i,
  output logic [GRP_W-1:0]                 grp_o,
  output logic [IDX_W-1:0]                 idx_o,
  output logic                             grp_last_o,
  output logic                             last_o,
  output logic                             done_o,
  output logic                             drop_o,
  output logic [STATE_W-1:0]               state_o
);

  localparam logic [GRP_W-1:0] GRP_MAX = GRP_W'(N_GROUPS - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(ELEMS - 1);

  state_e           state_q;
  logic [GRP_W-1:0] grp_q;
  logic [IDX_W-1:0] idx_q;
  logic             loop_q;
  logic             done_q;
  logic             drop_q;

  logic at_grp_end;
  logic at_last;
  logic load;

  assign at_grp_end = (idx_q == IDX_MAX);
  assign at_last    = at_grp_end && (grp_q == GRP_MAX);
  // A capture is honoured only outside SHOW and only when not overridden by abort.
  assign load       = capture_i && !abort_i && (state_q != S_SHOW);

  result_bank #(
    .DATA_W  (DATA_W),
    .N_GROUPS(N_GROUPS),
    .ELEMS   (ELEMS),
    .GRP_W   (GRP_W),
    .IDX_W   (IDX_W)
  ) u_bank (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_i   (load),
    .results_i(results_i),
    .grp_i    (grp_q),
    .idx_i    (idx_q),
    .word_o   (dout_o)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      grp_q   <= '0;
      idx_q   <= '0;
      loop_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else if (abort_i) begin
      state_q <= S_IDLE;
      grp_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      drop_q <= 1'b0;
      case (state_q)
        S_SHOW: begin
          drop_q <= capture_i;
          if (dout_ready_i) begin
            if (at_grp_end) begin
              idx_q <= '0;
              grp_q <= (grp_q == GRP_MAX) ? '0 : grp_q + 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
            if (at_last && !loop_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          if (capture_i) begin
            state_q <= S_SHOW;
            loop_q  <= loop_i;
            grp_q   <= '0;
            idx_q   <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign dout_valid_o = (state_q == S_SHOW);
  assign grp_o        = grp_q;
  assign idx_o        = idx_q;
  assign grp_last_o   = dout_valid_o && at_grp_end;
  assign last_o       = dout_valid_o && at_last;
  assign done_o       = done_q;
  assign drop_o       = drop_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_result_display_seq.sv
// tb/tb_result_display_seq.sv - directed bench for the default build and a 16-bit single-word build
module tb_result_display_seq;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;

  // Default build: 3 groups x 4 words x 8 bits
  logic [95:0] results_a;
  logic        capture_a, loop_a, abort_a, ready_a;
  logic [7:0]  dout_a;
  logic        valid_a, grp_last_a, last_a, done_a, drop_a;
  logic [1:0]  grp_a, idx_a, state_a;

  // Degenerate build: 1 group x 1 word x 16 bits
  logic [15:0] results_b;
  logic        capture_b, loop_b, abort_b, ready_b;
  logic [15:0] dout_b;
  logic        valid_b, grp_last_b, last_b, done_b, drop_b;
  logic        grp_b, idx_b;
  logic [1:0]  state_b;

  result_display_seq dut_a (
    .clk(clk), .reset_n(reset_n), .results_i(results_a), .capture_i(capture_a),
    .loop_i(loop_a), .abort_i(abort_a), .dout_o(dout_a), .dout_valid_o(valid_a),
    .dout_ready_i(ready_a), .grp_o(grp_a), .idx_o(idx_a), .grp_last_o(grp_last_a),
    .last_o(last_a), .done_o(done_a), .drop_o(drop_a), .state_o(state_a)
  );

  result_display_seq #(.DATA_W(16), .N_GROUPS(1), .ELEMS(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .results_i(results_b), .capture_i(capture_b),
    .loop_i(loop_b), .abort_i(abort_b), .dout_o(dout_b), .dout_valid_o(valid_b),
    .dout_ready_i(ready_b), .grp_o(grp_b), .idx_o(idx_b), .grp_last_o(grp_last_b),
    .last_o(last_b), .done_o(done_b), .drop_o(drop_b), .state_o(state_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ramp();
    for (int k = 0; k < 12; k++) results_a[k*8 +: 8] = 8'(16 + k);
  endtask

  initial begin
    reset_n = 1'b0;
    capture_a = 0; loop_a = 0; abort_a = 0; ready_a = 1;
    capture_b = 0; loop_b = 0; abort_b = 0; ready_b = 1;
    results_b = '0;
    load_ramp();
    #2;
    check("rst_state", 32'(state_a), 0);
    check("rst_valid", 32'(valid_a), 0);
    check("rst_dout",  32'(dout_a), 0);
    check("rst_done",  32'(done_a), 0);
    check("rst_b_last", 32'(last_b), 0);
    tick();
    reset_n = 1'b1;
    tick();

    // One-shot playback with ready held high
    capture_a = 1; tick(); capture_a = 0;
    for (int j = 0; j < 12; j++) begin
      check("os_valid", 32'(valid_a), 1);
      check("os_dout", 32'(dout_a), 32'(16 + j));
      check("os_grp", 32'(grp_a), 32'(j / 4));
      check("os_idx", 32'(idx_a), 32'(j % 4));
      check("os_grp_last", 32'(grp_last_a), 32'(j % 4 == 3));
      check("os_last", 32'(last_a), 32'(j == 11));
      check("os_done_early", 32'(done_a), 0);
      tick();
    end
    check("os_done_state", 32'(state_a), 2);
    check("os_done", 32'(done_a), 1);
    check("os_done_valid", 32'(valid_a), 0);
    tick();
    check("os_idle_state", 32'(state_a), 0);
    check("os_idle_done", 32'(done_a), 0);

    // Backpressure on word 5, then a capture while busy
    capture_a = 1; tick(); capture_a = 0;
    for (int j = 0; j < 5; j++) tick();
    ready_a = 0;
    for (int j = 0; j < 3; j++) begin
      check("bp_dout", 32'(dout_a), 32'h15);
      check("bp_grp", 32'(grp_a), 1);
      check("bp_idx", 32'(idx_a), 1);
      check("bp_valid", 32'(valid_a), 1);
      tick();
    end
    check("bp_hold_end", 32'(dout_a), 32'h15);
    ready_a = 1;
    tick();
    check("bp_release", 32'(dout_a), 32'h16);
    results_a = '1;
    capture_a = 1; tick(); capture_a = 0;
    check("drop_pulse", 32'(drop_a), 1);
    check("drop_dout", 32'(dout_a), 32'h17);
    check("drop_state", 32'(state_a), 1);
    tick();
    check("drop_clear", 32'(drop_a), 0);
    check("drop_dout8", 32'(dout_a), 32'h18);
    for (int j = 9; j < 12; j++) begin
      tick();
      check("drop_tail", 32'(dout_a), 32'(16 + j));
    end
    tick();
    check("drop_done", 32'(done_a), 1);
    tick();

    // Loop playback wraps, then abort
    load_ramp();
    loop_a = 1; capture_a = 1; tick(); capture_a = 0; loop_a = 0;
    for (int j = 0; j < 11; j++) tick();
    check("lp_last_word", 32'(dout_a), 32'h1B);
    check("lp_last", 32'(last_a), 1);
    tick();
    check("lp_wrap_dout", 32'(dout_a), 32'h10);
    check("lp_wrap_grp", 32'(grp_a), 0);
    check("lp_wrap_idx", 32'(idx_a), 0);
    check("lp_wrap_valid", 32'(valid_a), 1);
    check("lp_no_done", 32'(done_a), 0);
    abort_a = 1; tick(); abort_a = 0;
    check("ab_state", 32'(state_a), 0);
    check("ab_valid", 32'(valid_a), 0);
    check("ab_done", 32'(done_a), 0);

    // Abort wins over a same-cycle capture
    abort_a = 1; capture_a = 1; tick(); abort_a = 0; capture_a = 0;
    check("abcap_state", 32'(state_a), 0);
    check("abcap_drop", 32'(drop_a), 0);
    tick();
    check("abcap_stay", 32'(state_a), 0);

    // Asynchronous reset in the middle of playback
    capture_a = 1; tick(); capture_a = 0;
    for (int j = 0; j < 6; j++) tick();
    check("mid_grp", 32'(grp_a), 1);
    check("mid_idx", 32'(idx_a), 2);
    reset_n = 1'b0;
    #1;
    check("arst_state", 32'(state_a), 0);
    check("arst_valid", 32'(valid_a), 0);
    check("arst_dout", 32'(dout_a), 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Single-word build, including capture in the DONE cycle
    results_b = 16'hBEEF;
    capture_b = 1; tick(); capture_b = 0;
    check("b_valid", 32'(valid_b), 1);
    check("b_dout", 32'(dout_b), 32'hBEEF);
    check("b_last", 32'(last_b), 1);
    check("b_grp_last", 32'(grp_last_b), 1);
    check("b_grp", 32'(grp_b), 0);
    check("b_idx", 32'(idx_b), 0);
    tick();
    check("b_done_state", 32'(state_b), 2);
    check("b_done", 32'(done_b), 1);
    results_b = 16'hCAFE;
    capture_b = 1; tick(); capture_b = 0;
    check("b_restart_state", 32'(state_b), 1);
    check("b_restart_drop", 32'(drop_b), 0);
    check("b_restart_dout", 32'(dout_b), 32'hCAFE);
    tick();
    check("b_done2", 32'(done_b), 1);
    tick();
    check("b_idle", 32'(state_b), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end

endmodule
